// File: rtl/reg_file_nway_if.sv
// reg_file_nway_if: read-port and writeback bundle for the N-way register file.
// master = pipeline side (drives reads/retirements), slave = register file.
interface reg_file_nway_if #(
    parameter int NUM_WAYS = 2,
    parameter int XLEN     = 64,
    parameter int PID_W    = 2
);
    // per way {rs2, rs1}
    logic [2*NUM_WAYS-1:0]      rsReadEnable_i;
    logic [10*NUM_WAYS-1:0]     rsAddr_i;
    logic [2*XLEN*NUM_WAYS-1:0] rsReadData_o;

    // per way retirement
    logic [NUM_WAYS-1:0]        wbValid_i;
    logic [NUM_WAYS-1:0]        rdWriteEnable_i;
    logic [5*NUM_WAYS-1:0]      rdAddr_i;
    logic [XLEN*NUM_WAYS-1:0]   rdData_i;
    logic [PID_W*NUM_WAYS-1:0]  WBU_pID_i;
    logic [NUM_WAYS-1:0]        ready_o;
    logic [PID_W-1:0]           expPid_o;

    modport master (
        output rsReadEnable_i,
        output rsAddr_i,
        input  rsReadData_o,
        output wbValid_i,
        output rdWriteEnable_i,
        output rdAddr_i,
        output rdData_i,
        output WBU_pID_i,
        input  ready_o,
        input  expPid_o
    );

    modport slave (
        input  rsReadEnable_i,
        input  rsAddr_i,
        output rsReadData_o,
        input  wbValid_i,
        input  rdWriteEnable_i,
        input  rdAddr_i,
        input  rdData_i,
        input  WBU_pID_i,
        output ready_o,
        output expPid_o
    );
endinterface

// File: rtl/reg_file_nway.sv
// reg_file_nway: 32 x XLEN register file with NUM_WAYS in-order retirement ports.
// Ports: clk, reset (sync, active-high), bus (reg_file_nway_if.slave):
//   2*NUM_WAYS combinational read ports, NUM_WAYS writeback ways committed
//   in program order (pID chain starting at expPid_o), ready_o per way.
// Option: define REGFILE_BYPASS_EN to forward same-cycle chained writes to reads.
module reg_file_nway #(
    parameter int NUM_WAYS = 2,
    parameter int XLEN     = 64,
    parameter int PID_W    = 2
) (
    input logic            clk,
    input logic            reset,
    reg_file_nway_if.slave bus
);
    localparam int NRD  = 2 * NUM_WAYS;
    localparam int WIDX = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef logic [PID_W-1:0] pid_t;
    typedef logic [WIDX-1:0]  way_t;

    logic [XLEN-1:0] regs_q [32];
    pid_t            expPid_q;
    pid_t            expPid_d;

    // Chain slot j holds the way retiring pID expPid+j.
    logic [NUM_WAYS-1:0] slotHit;
    logic [NUM_WAYS-1:0] slotLive;
    way_t                slotWay [NUM_WAYS];

    logic [NUM_WAYS-1:0] wrEn;
    logic [4:0]          wrAddr [NUM_WAYS];
    logic [XLEN-1:0]     wrData [NUM_WAYS];

    logic [NUM_WAYS-1:0] ready_d;
    logic [NRD*XLEN-1:0] rdata;

    // Slot match: descending scan so the lowest way index wins duplicates.
    always_comb begin
        for (int j = 0; j < NUM_WAYS; j++) begin
            slotHit[j] = 1'b0;
            slotWay[j] = '0;
            for (int k = NUM_WAYS - 1; k >= 0; k--) begin
                if (bus.wbValid_i[k] &&
                    bus.WBU_pID_i[k*PID_W +: PID_W] ==
                    pid_t'(expPid_q + pid_t'(j))) begin
                    slotHit[j] = 1'b1;
                    slotWay[j] = way_t'(k);
                end
            end
        end
    end

    // A slot is live only if every earlier slot is filled; reset kills all.
    always_comb begin
        logic live;
        live = ~reset;
        for (int j = 0; j < NUM_WAYS; j++) begin
            live        = live & slotHit[j];
            slotLive[j] = live;
        end
    end

    // Ready flags and order advance.
    always_comb begin
        ready_d   = '0;
        expPid_d  = expPid_q;
        for (int j = 0; j < NUM_WAYS; j++) begin
            if (slotLive[j]) begin
                ready_d[slotWay[j]] = 1'b1;
                expPid_d            = expPid_d + pid_t'(1);
            end
        end
    end

    // Per-slot write ports; x0 writes are dropped here.
    always_comb begin
        for (int j = 0; j < NUM_WAYS; j++) begin
            wrAddr[j] = bus.rdAddr_i[slotWay[j]*5 +: 5];
            wrData[j] = bus.rdData_i[slotWay[j]*XLEN +: XLEN];
            wrEn[j]   = slotLive[j] &&
                        bus.rdWriteEnable_i[slotWay[j]] &&
                        (wrAddr[j] != 5'd0);
        end
    end

    // Ascending slot order: the latest instruction's write lands last.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= '0;
            end
            expPid_q <= '0;
        end else begin
            for (int j = 0; j < NUM_WAYS; j++) begin
                if (wrEn[j]) begin
                    regs_q[wrAddr[j]] <= wrData[j];
                end
            end
            expPid_q <= expPid_d;
        end
    end

    // Read ports: port p = 2*way + {0:rs1, 1:rs2}.
    always_comb begin
        logic [4:0]      a;
        logic [XLEN-1:0] v;
        rdata = '0;
        for (int p = 0; p < NRD; p++) begin
            a = bus.rsAddr_i[p*5 +: 5];
            v = regs_q[a];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NUM_WAYS; j++) begin
                if (wrEn[j] && wrAddr[j] == a) begin
                    v = wrData[j];
                end
            end
`endif
            if (!bus.rsReadEnable_i[p] || a == 5'd0) begin
                v = '0;
            end
            rdata[p*XLEN +: XLEN] = v;
        end
    end

    assign bus.rsReadData_o = rdata;
    assign bus.ready_o      = ready_d;
    assign bus.expPid_o     = expPid_q;

endmodule

// File: tb/tb_reg_file_nway.sv
// tb_reg_file_nway: directed and random checks of reg_file_nway against
// a simple array/program-order model.
module tb_reg_file_nway;
    localparam int NW = 2;
    localparam int XL = 64;
    localparam int PW = 2;
    localparam int NP = 1 << PW;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    reg_file_nway_if #(.NUM_WAYS(NW), .XLEN(XL), .PID_W(PW)) bus ();

    reg_file_nway #(.NUM_WAYS(NW), .XLEN(XL), .PID_W(PW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    logic [XL-1:0] mregs [32];
    int            m_exp;
    int            m_len;
    int            m_way [4];
    logic [NW-1:0] m_rdy;

    task automatic model_chain();
        m_len = 0;
        m_rdy = '0;
        if (!reset) begin
            for (int j = 0; j < NW; j++) begin
                int want;
                int hit;
                want = (m_exp + j) % NP;
                hit  = -1;
                for (int k = 0; k < NW; k++)
                    if (hit < 0 && bus.wbValid_i[k] &&
                        int'(bus.WBU_pID_i[k*PW +: PW]) == want)
                        hit = k;
                if (hit < 0) break;
                m_way[j]   = hit;
                m_rdy[hit] = 1'b1;
                m_len++;
            end
        end
    endtask

    function automatic logic [XL-1:0] mread(int p);
        logic [4:0]    a;
        logic [XL-1:0] v;
        a = bus.rsAddr_i[p*5 +: 5];
        if (!bus.rsReadEnable_i[p] || a == 5'd0) return '0;
        v = mregs[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < m_len; j++) begin
            int k;
            k = m_way[j];
            if (bus.rdWriteEnable_i[k] && bus.rdAddr_i[k*5 +: 5] == a)
                v = bus.rdData_i[k*XL +: XL];
        end
`endif
        return v;
    endfunction

    task automatic check_val(string tag, logic [XL-1:0] got,
                             logic [XL-1:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    task automatic check_outputs(string tag);
        #1;
        model_chain();
        check_val({tag, ".rdy"}, XL'(bus.ready_o), XL'(m_rdy));
        check_val({tag, ".exp"}, XL'(bus.expPid_o), XL'(m_exp));
        for (int p = 0; p < 2*NW; p++)
            check_val($sformatf("%s.rd%0d", tag, p),
                      bus.rsReadData_o[p*XL +: XL], mread(p));
    endtask

    task automatic tick();
        model_chain();
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < 32; r++) mregs[r] = '0;
            m_exp = 0;
        end else begin
            for (int j = 0; j < m_len; j++) begin
                int k;
                k = m_way[j];
                if (bus.rdWriteEnable_i[k] && bus.rdAddr_i[k*5 +: 5] != 0)
                    mregs[bus.rdAddr_i[k*5 +: 5]] = bus.rdData_i[k*XL +: XL];
            end
            m_exp = (m_exp + m_len) % NP;
        end
        @(negedge clk);
    endtask

    task automatic step(string tag);
        check_outputs(tag);
        tick();
    endtask

    task automatic idle();
        bus.rsReadEnable_i  = '0;
        bus.rsAddr_i        = '0;
        bus.wbValid_i       = '0;
        bus.rdWriteEnable_i = '0;
        bus.rdAddr_i        = '0;
        bus.rdData_i        = '0;
        bus.WBU_pID_i       = '0;
    endtask

    task automatic way(int k, bit we, int rd, logic [XL-1:0] d, int pid);
        bus.wbValid_i[k]          = 1'b1;
        bus.rdWriteEnable_i[k]    = we;
        bus.rdAddr_i[k*5 +: 5]    = 5'(rd);
        bus.rdData_i[k*XL +: XL]  = d;
        bus.WBU_pID_i[k*PW +: PW] = PW'(pid);
    endtask

    task automatic rport(int p, int a);
        bus.rsReadEnable_i[p] = 1'b1;
        bus.rsAddr_i[p*5 +: 5] = 5'(a);
    endtask

    function automatic logic [XL-1:0] rdp(int p);
        return bus.rsReadData_o[p*XL +: XL];
    endfunction

    initial begin
        int seq [4];
        logic [XL-1:0] byp;
        seq = '{3, 0, 1, 2};
        for (int r = 0; r < 32; r++) mregs[r] = '0;
        m_exp = 0;
        reset = 1'b1;
        idle();
        @(negedge clk);
        step("rst0");
        step("rst1");
        reset = 1'b0;

        // all registers zero after reset
        for (int b = 1; b < 32; b += 4) begin
            idle();
            for (int p = 0; p < 4; p++)
                if (b + p < 32) rport(p, b + p);
            #1;
            check_val("r33.rdy", XL'(bus.ready_o), '0);
            check_val("r33.exp", XL'(bus.expPid_o), '0);
            for (int p = 0; p < 4; p++)
                check_val($sformatf("r33.x%0d", b + p), rdp(p), '0);
            step("r33");
        end

        // out-of-order way1 waits for way0
        idle();
        way(1, 1, 5, 64'hAA, 1);
        #1;
        check_val("r34.notrdy", XL'(bus.ready_o), '0);
        step("r34a");
        way(0, 1, 6, 64'h11, 0);
        #1;
        check_val("r34.rdy", XL'(bus.ready_o), XL'(2'b11));
        step("r34b");
        idle();
        rport(0, 6);
        rport(1, 5);
        #1;
        check_val("r34.x6", rdp(0), 64'h11);
        check_val("r34.x5", rdp(1), 64'hAA);
        check_val("r34.exp", XL'(bus.expPid_o), 64'd2);
        step("r34c");

        // same rd in one cycle: later program order wins
        idle();
        way(0, 1, 7, 64'h1, 2);
        way(1, 1, 7, 64'h2, 3);
        step("r35a");
        idle();
        rport(0, 7);
        #1;
        check_val("r35.x7", rdp(0), 64'h2);
        check_val("r35.exp", XL'(bus.expPid_o), 64'd0);
        step("r35b");

        // single retirements, pID wrap
        idle();
        way(0, 0, 0, '0, 0);
        step("r36a");
        way(0, 0, 0, '0, 1);
        step("r36b");
        for (int i = 0; i < 4; i++) begin
            way(0, 0, 0, '0, (2 + i) % NP);
            step("r36");
            #1;
            check_val($sformatf("r36.exp%0d", i),
                      XL'(bus.expPid_o), XL'(seq[i]));
        end

        // same-cycle read of a chained write; x0 stays zero
`ifdef REGFILE_BYPASS_EN
        byp = 64'h55;
`else
        byp = 64'h0;
`endif
        idle();
        way(0, 1, 8, 64'h55, 2);
        rport(0, 8);
        #1;
        check_val("r37.byp", rdp(0), byp);
        step("r37a");
        idle();
        rport(0, 8);
        #1;
        check_val("r37.x8", rdp(0), 64'h55);
        step("r37b");
        way(0, 1, 0, 64'hFF, 3);
        rport(0, 0);
        #1;
        check_val("r37.x0a", rdp(0), '0);
        step("r37c");
        idle();
        rport(0, 0);
        #1;
        check_val("r37.x0b", rdp(0), '0);
        step("r37d");

        // reset kills a valid chain
        idle();
        way(0, 1, 9, 64'h77, 0);
        way(1, 1, 10, 64'h66, 1);
        reset = 1'b1;
        #1;
        check_val("r38.rdy", XL'(bus.ready_o), '0);
        step("r38a");
        reset = 1'b0;
        idle();
        rport(0, 9);
        rport(1, 10);
        rport(2, 8);
        #1;
        check_val("r38.exp", XL'(bus.expPid_o), '0);
        check_val("r38.x9", rdp(0), '0);
        check_val("r38.x10", rdp(1), '0);
        check_val("r38.x8", rdp(2), '0);
        step("r38b");

        // random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            reset = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < NW; k++)
                if ($urandom_range(0, 3) != 0)
                    way(k, 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 15)),
                        {$urandom, $urandom},
                        (m_exp + int'($urandom_range(0, NW))) % NP);
            for (int p = 0; p < 2*NW; p++)
                if ($urandom_range(0, 4) != 0)
                    rport(p, int'($urandom_range(0, 15)));
            step("rnd");
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
